// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: state encoding, word width, reset PC and bubble instruction.
package fetch_unit_pkg;

   localparam int WORD_W = 16;

   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT  = 16'h0000;
   localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 16'h0800;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      HOLD  = 2'b10,
      NEXT  = 2'b11
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: registered req/addr from the fetch unit, ready/data back from memory.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic              memReq;
   logic [WORD_W-1:0] memAddr;
   logic              memReady;
   logic [WORD_W-1:0] memData;

   modport master (output memReq, memAddr, input memReady, memData);
   modport slave  (input memReq, memAddr, output memReady, memData);

endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory, delivers {pcOut, instructionOut} to IF/ID.
// Two cycles per instruction with zero-wait memory; stall parks the fetched word in HOLD/NEXT.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] nextPCIn,
   input  logic              stall,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirectPC,
   fetch_unit_if.master      mem,
   output logic [WORD_W-1:0] pcOut,
   output logic [WORD_W-1:0] instructionOut,
   output logic              valid
);

   fetch_state_t      state, state_nxt;
   logic [WORD_W-1:0] pc, pc_nxt;
   logic [WORD_W-1:0] hold_q, hold_nxt;
   logic              req_q, req_nxt;
   logic [WORD_W-1:0] addr_q, addr_nxt;
   logic [WORD_W-1:0] pc_out_nxt;
   logic [WORD_W-1:0] instr_nxt;
   logic              valid_nxt;

   assign mem.memReq  = req_q;
   assign mem.memAddr = addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         hold_q         <= '0;
         req_q          <= 1'b0;
         addr_q         <= RESET_PC;
         pcOut          <= '0;
         instructionOut <= NOP_INSTR;
         valid          <= 1'b0;
      end else begin
         state          <= state_nxt;
         pc             <= pc_nxt;
         hold_q         <= hold_nxt;
         req_q          <= req_nxt;
         addr_q         <= addr_nxt;
         pcOut          <= pc_out_nxt;
         instructionOut <= instr_nxt;
         valid          <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      hold_nxt   = hold_q;
      req_nxt    = req_q;
      addr_nxt   = addr_q;
      pc_out_nxt = pcOut;
      instr_nxt  = instructionOut;
      valid_nxt  = valid;

      if (redirect) begin
         // Withdraw any request; FETCH re-issues at the new PC one cycle later.
         state_nxt  = FETCH;
         pc_nxt     = redirectPC;
         hold_nxt   = '0;
         req_nxt    = 1'b0;
         addr_nxt   = redirectPC;
         pc_out_nxt = redirectPC;
         instr_nxt  = NOP_INSTR;
         valid_nxt  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = FETCH;
               req_nxt   = 1'b1;
               addr_nxt  = pc;
            end
            FETCH: begin
               if (!req_q) begin
                  // Entered via redirect with no request outstanding yet.
                  req_nxt  = 1'b1;
                  addr_nxt = pc;
               end else if (mem.memReady) begin
                  req_nxt = 1'b0;
                  if (stall) begin
                     hold_nxt  = mem.memData;
                     state_nxt = HOLD;
                  end else begin
                     pc_out_nxt = pc;
                     instr_nxt  = mem.memData;
                     valid_nxt  = 1'b1;
                     state_nxt  = NEXT;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  pc_out_nxt = pc;
                  instr_nxt  = hold_q;
                  valid_nxt  = 1'b1;
                  state_nxt  = NEXT;
               end
            end
            NEXT: begin
               if (!stall) begin
                  pc_nxt    = nextPCIn;
                  req_nxt   = 1'b1;
                  addr_nxt  = nextPCIn;
                  state_nxt = FETCH;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule
